// File: rtl/cpu_types_pkg.sv
// Shared pipeline enums for the CPU datapath.
// Holds the hazard-unit pipe-state command used by every inter-stage register.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipeline_sat_counter.sv
// Saturating up-counter with synchronous clear for the perf-monitor path.
// Clear wins over increment, and the counter sticks at all-ones.
module pipeline_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                       r_cnt <= '0;
    else if (clr)                    r_cnt <= '0;
    else if (inc && (r_cnt != '1))   r_cnt <= r_cnt + 1'b1;
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Reusable inter-stage pipeline register: main entry plus one skid entry,
// valid/ready handshake, hazard-unit enable/stall/NOP command and flush.
module pipeline_stage_skid
  import cpu_types_pkg::*;
#(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 96,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  pipe_state_t       state_i,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_main_vld, r_skid_vld;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data;

  logic w_en, w_clear, w_acc, w_pop;

  assign w_en     = (state_i == PIPE_ENABLE) && !flush_i;
  assign w_clear  = flush_i || (state_i == PIPE_NOP);
  assign in_ready = !r_skid_vld && w_en;
  assign w_acc    = in_valid && in_ready;
  assign w_pop    = r_main_vld && out_ready && w_en;

  // Accept is only possible with the skid empty, so a skid->main move never
  // coincides with a new input needing the skid slot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_main_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (w_clear) begin
      r_main_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= '0;
      if (CLEAR_DATA) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else if (w_en) begin
      if (!r_main_vld || w_pop) begin
        if (r_skid_vld) begin
          r_main_vld  <= 1'b1;
          r_main_ctrl <= r_skid_ctrl;
          r_main_data <= r_skid_data;
          r_skid_vld  <= 1'b0;
        end else if (w_acc) begin
          r_main_vld  <= 1'b1;
          r_main_ctrl <= in_ctrl;
          r_main_data <= in_data;
        end else begin
          r_main_vld  <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid_vld  <= 1'b1;
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign out_valid = r_main_vld;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

  logic w_stall_inc, w_bubble_inc;
  assign w_stall_inc  = r_main_vld && (!out_ready || (state_i == PIPE_STALL));
  assign w_bubble_inc = !r_main_vld;

  pipeline_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .inc (w_stall_inc),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  pipeline_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .inc (w_bubble_inc),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

endmodule
